// File: rtl/move_input_pkg.sv
// move_input_pkg: shared register map, state encoding and field offsets for move_input_ctrl
package move_input_pkg;
    localparam logic [1:0] ADDR_LEVEL = 2'd0;
    localparam logic [1:0] ADDR_CAP   = 2'd1;
    localparam logic [1:0] ADDR_CFG   = 2'd2;
    localparam logic [1:0] ADDR_MASK  = 2'd3;
    localparam int DAS_LSB   = 0;
    localparam int ARR_LSB   = 8;
    localparam int STATE_LSB = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} btn_state_t;
endpackage

// File: rtl/move_btn_fsm.sv
// move_btn_fsm: per-button synchroniser, tick-based debouncer and auto-repeat event generator
module move_btn_fsm
    import move_input_pkg::*;
#(
    parameter int DEB_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_in,
    input  logic [7:0] das,
    input  logic [7:0] arr,
    output logic       level,
    output logic [1:0] state,
    output logic       evt
);
    localparam int DW = $clog2(DEB_TICKS + 1);

    logic          sync_a, sync_b;
    logic [DW-1:0] deb_cnt;
    logic [7:0]    cnt, lim;
    btn_state_t    st;
    logic          deb_done, rise, fall;

    assign deb_done = tick && (sync_b != level) && (deb_cnt == DW'(DEB_TICKS - 1));
    assign rise     = deb_done && sync_b;
    assign fall     = deb_done && !sync_b;
    // A zero delay or period register behaves as one tick
    assign lim      = st == DELAY ? (das == 8'd0 ? 8'd0 : das - 8'd1)
                                  : (arr == 8'd0 ? 8'd0 : arr - 8'd1);
    assign state    = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync_a <= btn_in;
            sync_b <= sync_a;
            if (sync_b == level)
                deb_cnt <= '0;
            else if (deb_done) begin
                level   <= sync_b;
                deb_cnt <= '0;
            end else if (tick)
                deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // >= rather than == so a shortened DAS/ARR write cannot strand cnt above the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st  <= IDLE;
            cnt <= '0;
            evt <= 1'b0;
        end else begin
            evt <= 1'b0;
            if (fall) begin
                st  <= IDLE;
                cnt <= '0;
            end else if (st == IDLE) begin
                if (rise) begin
                    evt <= 1'b1;
                    cnt <= '0;
                    st  <= DELAY;
                end
            end else if (tick) begin
                if (cnt >= lim) begin
                    evt <= 1'b1;
                    cnt <= '0;
                    st  <= REPEAT;
                end else
                    cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/move_input_ctrl.sv
// move_input_ctrl: Avalon-MM slave turning move buttons into debounced auto-repeat events
// with a sticky W1C capture register and a maskable level interrupt.
module move_input_ctrl
    import move_input_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int TICK_DIV  = 50000,
    parameter int DEB_TICKS = 10,
    parameter int DAS_RST   = 170,
    parameter int ARR_RST   = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [N_BTN-1:0] btn_in
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]    pre;
    logic             tick;
    logic [N_BTN-1:0] level, evt, cap, mask;
    logic [7:0]       das, arr;
    logic [1:0]       st [N_BTN];
    logic [31:0]      lvl_word, rd_mux;
    logic             unused_ok;

    assign tick      = pre == PW'(TICK_DIV - 1);
    assign unused_ok = ^{read, writedata[31:16]};

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        move_btn_fsm #(.DEB_TICKS(DEB_TICKS)) u_btn (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .btn_in (btn_in[i]),
            .das    (das),
            .arr    (arr),
            .level  (level[i]),
            .state  (st[i]),
            .evt    (evt[i])
        );
    end

    always_comb begin
        lvl_word = '0;
        lvl_word[N_BTN-1:0] = level;
        for (int i = 0; i < N_BTN; i++)
            lvl_word[STATE_LSB + 2*i +: 2] = st[i];
    end

    assign rd_mux = address == ADDR_LEVEL ? lvl_word
                  : address == ADDR_CAP   ? 32'(cap)
                  : address == ADDR_CFG   ? {16'd0, arr, das}
                  : 32'(mask);

    // Events are OR'd in after the clear so a coincident event always survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre      <= '0;
            cap      <= '0;
            mask     <= '0;
            das      <= 8'(DAS_RST);
            arr      <= 8'(ARR_RST);
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            cap <= ((write && address == ADDR_CAP) ? cap & ~writedata[N_BTN-1:0] : cap) | evt;
            if (write && address == ADDR_CFG) begin
                das <= writedata[DAS_LSB +: 8];
                arr <= writedata[ARR_LSB +: 8];
            end
            if (write && address == ADDR_MASK)
                mask <= writedata[N_BTN-1:0];
            irq      <= |(cap & mask);
            readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_move_input_ctrl.sv
// tb_move_input_ctrl: directed self-checking bench for move_input_ctrl
module tb_move_input_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  btn_in = '0;
    int          total_cnt = 0;
    int          pass_cnt = 0;

    move_input_ctrl #(
        .N_BTN(4), .TICK_DIV(4), .DEB_TICKS(2), .DAS_RST(3), .ARR_RST(50)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .btn_in    (btn_in)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        write = 1'b1;
        cyc(1);
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        cyc(1);
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        cyc(3);
        reset = 1'b0;
        cyc(2);
        wr(2'd3, 32'hF);
        wr(2'd2, 32'h1234);
        rd(2'd2, d);
        total_cnt++; if (d !== 32'h1234) $display("FAIL cfg_write: got %h want %h", d, 32'h1234); else pass_cnt++;
        address = 2'd2;
        cyc(2);
        reset = 1'b1;
        #1;
        total_cnt++; if (readdata !== 32'h0) $display("FAIL reset_readdata: got %h want 0", readdata); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else pass_cnt++;
        cyc(2);
        reset = 1'b0;
        rd(2'd2, d);
        total_cnt++; if (d !== 32'h3203) $display("FAIL reset_cfg: got %h want %h", d, 32'h3203); else pass_cnt++;
        rd(2'd3, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL reset_mask: got %h want 0", d); else pass_cnt++;
        rd(2'd1, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL reset_cap: got %h want 0", d); else pass_cnt++;
        rd(2'd0, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL reset_level: got %h want 0", d); else pass_cnt++;
    endtask

    task automatic test_debounce;
        logic [31:0] d;
        wr(2'd2, 32'h3264);
        btn_in[0] = 1'b1;
        cyc(3);
        btn_in[0] = 1'b0;
        cyc(20);
        rd(2'd0, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL glitch_level: got %h want 0", d); else pass_cnt++;
        rd(2'd1, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL glitch_cap: got %h want 0", d); else pass_cnt++;
        btn_in[0] = 1'b1;
        cyc(20);
        rd(2'd0, d);
        total_cnt++; if (d !== 32'h101) $display("FAIL hold_level_state: got %h want %h", d, 32'h101); else pass_cnt++;
        rd(2'd1, d);
        total_cnt++; if (d !== 32'h1) $display("FAIL hold_cap: got %h want 1", d); else pass_cnt++;
        wr(2'd1, 32'h1);
        cyc(20);
        rd(2'd1, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL single_event: got %h want 0", d); else pass_cnt++;
        btn_in[0] = 1'b0;
        cyc(20);
        rd(2'd0, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL release_level: got %h want 0", d); else pass_cnt++;
    endtask

    task automatic test_auto_repeat;
        int ev[$];
        int skip, first, n_in, bad;
        logic [31:0] d;
        wr(2'd2, 32'h0203);
        address = 2'd1;
        writedata = 32'h2;
        skip = 0;
        first = -1;
        btn_in[1] = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            cyc(1);
            write = 1'b0;
            if (first >= 0 && c == first + 78) btn_in[1] = 1'b0;
            if (skip > 0) skip--;
            else if (readdata[1]) begin
                ev.push_back(c);
                if (first < 0) first = c;
                write = 1'b1;
                skip = 1;
            end
        end
        write = 1'b0;
        n_in = 0;
        bad = 0;
        for (int i = 0; i < ev.size(); i++) begin
            if (ev[i] - first < 80) begin
                n_in++;
                if (i > 0 && ev[i] - ev[i-1] != (i == 1 ? 12 : 8)) bad++;
            end
        end
        total_cnt++; if (n_in !== 10) $display("FAIL repeat_count: got %0d want 10", n_in); else pass_cnt++;
        total_cnt++; if (bad !== 0) $display("FAIL repeat_gaps: got %0d bad gaps want 0", bad); else pass_cnt++;
        rd(2'd0, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL repeat_idle: got %h want 0", d); else pass_cnt++;
        wr(2'd1, 32'hF);
        cyc(40);
        rd(2'd1, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL repeat_after_release: got %h want 0", d); else pass_cnt++;
    endtask

    task automatic test_cap_irq;
        logic [31:0] d;
        logic irq_prev, found;
        wr(2'd2, 32'h3264);
        wr(2'd3, 32'h8);
        rd(2'd3, d);
        total_cnt++; if (d !== 32'h8) $display("FAIL mask_read: got %h want 8", d); else pass_cnt++;
        btn_in[2] = 1'b1;
        cyc(20);
        rd(2'd1, d);
        total_cnt++; if (d !== 32'h4) $display("FAIL masked_cap: got %h want 4", d); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("FAIL masked_irq: got %b want 0", irq); else pass_cnt++;
        btn_in[2] = 1'b0;
        address = 2'd1;
        irq_prev = irq;
        found = 1'b0;
        btn_in[3] = 1'b1;
        for (int c = 0; c < 40 && !found; c++) begin
            cyc(1);
            if (readdata[3]) found = 1'b1;
            else irq_prev = irq;
        end
        total_cnt++; if (found !== 1'b1) $display("FAIL irq_event_seen: got %b want 1", found); else pass_cnt++;
        total_cnt++; if (irq_prev !== 1'b0) $display("FAIL irq_before_cap: got %b want 0", irq_prev); else pass_cnt++;
        total_cnt++; if (irq !== 1'b1) $display("FAIL irq_after_cap: got %b want 1", irq); else pass_cnt++;
        wr(2'd1, 32'h8);
        rd(2'd1, d);
        total_cnt++; if (irq !== 1'b0) $display("FAIL irq_cleared: got %b want 0", irq); else pass_cnt++;
        total_cnt++; if (d !== 32'h4) $display("FAIL cap_other_kept: got %h want 4", d); else pass_cnt++;
        wr(2'd1, 32'h4);
        btn_in[3] = 1'b0;
        cyc(20);
    endtask

    task automatic test_simultaneous;
        logic [31:0] d;
        int ones;
        wr(2'd2, 32'h0);
        btn_in[0] = 1'b1;
        cyc(24);
        rd(2'd0, d);
        total_cnt++; if (d !== 32'h201) $display("FAIL sim_repeat_state: got %h want %h", d, 32'h201); else pass_cnt++;
        address = 2'd1;
        writedata = 32'h1;
        write = 1'b1;
        cyc(4);
        ones = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(1);
            if (readdata[0]) ones++;
        end
        write = 1'b0;
        total_cnt++; if (ones !== 10) $display("FAIL sim_event_wins: got %0d set cycles want 10", ones); else pass_cnt++;
    endtask

    task automatic test_reset_mid_hold;
        logic [31:0] d;
        int events, skip;
        rd(2'd0, d);
        total_cnt++; if (d !== 32'h201) $display("FAIL pre_reset_state: got %h want %h", d, 32'h201); else pass_cnt++;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        rd(2'd0, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL mid_reset_state: got %h want 0", d); else pass_cnt++;
        rd(2'd1, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL mid_reset_cap: got %h want 0", d); else pass_cnt++;
        events = 0;
        skip = 0;
        address = 2'd1;
        writedata = 32'h1;
        for (int c = 3; c <= 18; c++) begin
            cyc(1);
            write = 1'b0;
            if (skip > 0) skip--;
            else if (readdata[0]) begin
                events++;
                write = 1'b1;
                skip = 1;
            end
        end
        write = 1'b0;
        total_cnt++; if (events !== 1) $display("FAIL mid_reset_event: got %0d want 1", events); else pass_cnt++;
        btn_in[0] = 1'b0;
        cyc(20);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_auto_repeat();
        test_cap_irq();
        test_simultaneous();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
